// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM slave: byte/halfword/word single transfers into a word-organised memory, OKAY or two-cycle ERROR.
// Latency: OKAY data phase lasts WAIT_STATES+1 cycles; ERROR data phase is always two cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; address phases are only taken when HREADY is high.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int                  AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0]          WS        = 4'(WAIT_STATES);
    localparam logic [HADDR_SIZE:0] MEM_BYTES = (HADDR_SIZE + 1)'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      be_q, be_d;
    logic            write_q, write_d;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic       accept;
    logic       addr_err;
    logic       slot_free;
    logic       do_write;
    logic [3:0] be_new;

    // Burst type, protection and the BUSY/IDLE distinction carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign accept = HSEL & HREADY & HTRANS[1];

    // Classify the address phase: illegal size, out of range, or misaligned.
    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'b010) begin
            addr_err = 1'b1;
        end
        if ({1'b0, HADDR} >= MEM_BYTES) begin
            addr_err = 1'b1;
        end
        if ((HSIZE == 3'b001) && HADDR[0]) begin
            addr_err = 1'b1;
        end
        if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) begin
            addr_err = 1'b1;
        end
    end

    // Byte lanes touched by the address phase.
    always_comb begin
        be_new = 4'b1111;
        case (HSIZE)
            3'b000:  be_new = 4'b0001 << HADDR[1:0];
            3'b001:  be_new = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
    end

    // Next state, wait counter, address-phase capture and bus response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        be_d      = be_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        slot_free = 1'b0;
        do_write  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                slot_free = 1'b1;
            end
            ST_DATA: begin
                HREADYOUT = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    slot_free = 1'b1;
                    do_write  = write_q;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
                slot_free = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new address phase can only be taken in the cycle the previous data phase ends.
        if (slot_free) begin
            state_d = ST_IDLE;
            if (accept) begin
                idx_d   = HADDR[AW+1:2];
                be_d    = be_new;
                write_d = HWRITE;
                if (addr_err) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = WS;
                end
            end
        end
    end

    // Control registers; the memory array itself is deliberately left unreset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Write lands at the edge closing the last data cycle, so a pipelined read sees it.
    always_ff @(posedge HCLK) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule
